// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan reader: bus width, hex glyph patterns, FSM states.
// Bit order of a pattern is {a,b,c,d,e,f,g}.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h72;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h47;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg_to_hex_encoder.sv
// Inverse of the board's hex-to-segment decode: pattern -> {legal, nibble}.
// Any pattern outside the sixteen glyphs is illegal and yields nibble 0.
module seg_to_hex_encoder
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal,
    output logic [3:0]       nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reconstructs the hex word shown on a multiplexed 7-segment bus, one debounced capture per digit dwell.
// Define SEG_ACTIVE_LOW_EN for common-anode boards (segment and digit lines inverted at the input register).
//
// state  | meaning
// IDLE   | digit enables zero or multi-hot; nothing to debounce
// SETTLE | one-hot sample seen, counting identical samples
// HELD   | digit captured for this dwell; wait for the bus to change
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic                    err_sticky
);

    localparam logic [7:0] S_CNT = 8'(STABLE_CYCLES);

    logic [SEG_W-1:0]        p_seg, prev_seg;
    logic [NUM_DIGITS-1:0]   p_en, prev_en;
    scan_state_t             state;
    logic [7:0]              cnt;
    logic [NUM_DIGITS-1:0]   mask, err;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic                    legal;
    logic [3:0]              nibble;
    logic                    onehot, same_p, new_dwell, do_capture;
    logic [7:0]              cnt_inc;
    logic [NUM_DIGITS-1:0]   cap_mask, cap_err;
    logic [4*NUM_DIGITS-1:0] cap_shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_seg <= '0;
            p_en  <= '0;
        end else begin
`ifdef SEG_ACTIVE_LOW_EN
            p_seg <= ~seg_in;
            p_en  <= ~digit_en;
`else
            p_seg <= seg_in;
            p_en  <= digit_en;
`endif
        end
    end

    seg_to_hex_encoder u_encoder (
        .seg    (p_seg),
        .legal  (legal),
        .nibble (nibble)
    );

    always_comb begin
        onehot    = (p_en != '0) && ((p_en & (p_en - NUM_DIGITS'(1))) == '0);
        same_p    = (p_seg == prev_seg) && (p_en == prev_en);
        new_dwell = (state == IDLE) || !same_p;
        cnt_inc   = cnt + 8'd1;
        // A fresh dwell counts as the first stable sample, so S=1 captures immediately.
        do_capture = onehot &&
                     ((new_dwell && S_CNT == 8'd1) ||
                      (!new_dwell && state == SETTLE && cnt_inc == S_CNT));
    end

    always_comb begin
        cap_shadow = shadow;
        cap_err    = err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (p_en[i]) begin
                cap_shadow[4*i +: 4] = nibble;
                cap_err[i]           = !legal;
            end
        end
        cap_mask = mask | p_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_seg    <= '0;
            prev_en     <= '0;
            state       <= IDLE;
            cnt         <= '0;
            mask        <= '0;
            err         <= '0;
            shadow      <= '0;
            value_out   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            prev_seg    <= p_seg;
            prev_en     <= p_en;
            frame_valid <= 1'b0;

            if (!onehot) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (new_dwell) begin
                cnt   <= 8'd1;
                state <= (S_CNT == 8'd1) ? HELD : SETTLE;
            end else if (state == SETTLE) begin
                cnt <= cnt_inc;
                if (cnt_inc == S_CNT) state <= HELD;
            end

            if (do_capture) begin
                shadow <= cap_shadow;
                if (!legal) err_sticky <= 1'b1;
                if (&cap_mask) begin
                    value_out   <= cap_shadow;
                    frame_error <= |cap_err;
                    frame_valid <= 1'b1;
                    mask        <= '0;
                    err         <= '0;
                end else begin
                    mask <= cap_mask;
                    err  <= cap_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: scoreboard of expected frames checked on every frame_valid pulse.
module tb_seg_scan_reader;
    import seg_pkg::*;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg_in;
    logic [ND-1:0] digit_en;
    logic [15:0]   value_out;
    logic          frame_valid, frame_error, err_sticky;

    typedef struct {
        logic [15:0] value;
        logic        ferr;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .digit_en    (digit_en),
        .value_out   (value_out),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    // Every frame pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_frame value_out=%h frame_error=%b", value_out, frame_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (value_out !== e.value || frame_error !== e.ferr) begin
                    tests_failed++;
                    $display("FAIL frame value_out=%h frame_error=%b expected %h/%b",
                             value_out, frame_error, e.value, e.ferr);
                end
            end
        end
    end

    task automatic set_bus(input logic [ND-1:0] en, input logic [6:0] pat);
`ifdef SEG_ACTIVE_LOW_EN
        digit_en = ~en;
        seg_in   = ~pat;
`else
        digit_en = en;
        seg_in   = pat;
`endif
    endtask

    task automatic drive(input logic [ND-1:0] en, input logic [6:0] pat, input int cycles);
        @(negedge clk);
        set_bus(en, pat);
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic drive_idle(input int cycles);
        @(negedge clk);
        set_bus('0, 7'h00);
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic push_exp(input logic [15:0] v, input logic fe);
        exp_t e;
        e.value = v;
        e.ferr  = fe;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s timeout pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_bus('0, 7'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (value_out !== 16'h0 || frame_valid !== 1'b0 || frame_error !== 1'b0 || err_sticky !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h/%b/%b/%b expected 0000/0/0/0",
                     value_out, frame_valid, frame_error, err_sticky);
        end
        tests_run++;
        if (dut.state !== IDLE || dut.mask !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_state got state=%0d mask=%b expected 0/0000", dut.state, dut.mask);
        end
    endtask

    task automatic test_basic_frame();
        drive(4'b0001, 7'h30, 3);
        drive(4'b0010, 7'h6D, 3);
        drive(4'b0100, 7'h79, 3);
        push_exp(16'h4321, 1'b0);
        drive(4'b1000, 7'h33, 3);
        drive_idle(2);
        wait_drain("basic_frame");
    endtask

    task automatic test_long_hold();
        drive(4'b0100, 7'h7E, 10);
        tests_run++;
        if (dut.mask !== 4'b0100) begin
            tests_failed++;
            $display("FAIL long_hold_mask got %b expected 0100", dut.mask);
        end
        drive(4'b0001, 7'h5B, 3);
        drive(4'b0010, 7'h4E, 3);
        push_exp(16'hD0C5, 1'b0);
        drive(4'b1000, 7'h3D, 3);
        drive_idle(2);
        wait_drain("long_hold_frame");
    endtask

    task automatic test_short_dwell();
        drive(4'b0010, 7'h7F, 2);
        drive(4'b0010, 7'h4E, 3);
        drive(4'b0001, 7'h7E, 3);
        drive(4'b0100, 7'h7E, 3);
        push_exp(16'h00C0, 1'b0);
        drive(4'b1000, 7'h7E, 3);
        drive_idle(2);
        wait_drain("short_dwell_frame");
    endtask

    task automatic test_illegal();
        drive(4'b0001, 7'h00, 3);
        drive(4'b0010, 7'h7E, 3);
        drive(4'b0100, 7'h7E, 3);
        push_exp(16'h0000, 1'b1);
        drive(4'b1000, 7'h7E, 3);
        drive_idle(2);
        wait_drain("illegal_frame");
        tests_run++;
        if (err_sticky !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky got %b expected 1", err_sticky);
        end
        drive(4'b0001, 7'h7F, 3);
        drive(4'b0010, 7'h7F, 3);
        drive(4'b0100, 7'h7F, 3);
        push_exp(16'h8888, 1'b0);
        drive(4'b1000, 7'h7F, 3);
        drive_idle(2);
        wait_drain("clean_after_illegal");
        tests_run++;
        if (err_sticky !== 1'b1 || frame_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL sticky_hold got sticky=%b frame_error=%b expected 1/0", err_sticky, frame_error);
        end
    endtask

    task automatic test_multi_hot();
        drive(4'b0011, 7'h7E, 5);
        tests_run++;
        if (dut.state !== IDLE || dut.mask !== 4'b0) begin
            tests_failed++;
            $display("FAIL multi_hot got state=%0d mask=%b expected 0/0000", dut.state, dut.mask);
        end
        drive_idle(2);
    endtask

    task automatic test_reset_mid_frame();
        drive(4'b0001, 7'h7E, 3);
        drive(4'b0010, 7'h7E, 3);
        drive(4'b0100, 7'h7E, 3);
        drive_idle(2);
        tests_run++;
        if (dut.mask !== 4'b0111) begin
            tests_failed++;
            $display("FAIL partial_mask got %b expected 0111", dut.mask);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (value_out !== 16'h0 || err_sticky !== 1'b0 || dut.mask !== 4'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got value=%h sticky=%b mask=%b expected 0000/0/0000",
                     value_out, err_sticky, dut.mask);
        end
        drive(4'b0001, 7'h47, 3);
        drive(4'b0010, 7'h5B, 3);
        drive(4'b0100, 7'h77, 3);
        push_exp(16'h7A5F, 1'b0);
        drive(4'b1000, 7'h72, 3);
        drive_idle(2);
        wait_drain("after_reset_frame");
        tests_run++;
        if (value_out !== 16'h7A5F) begin
            tests_failed++;
            $display("FAIL held_value got %h expected 7A5F", value_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_bus('0, 7'h00);
        test_reset();
        test_basic_frame();
        test_long_hold();
        test_short_dwell();
        test_illegal();
        test_multi_hot();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
